data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port. Accepts requests carrying mem_req, mem_we, mem_size, address and write data.
- Models a data RAM with configurable access latency and byte-lane writes. Returns aligned, sign- or zero-extended load data.
- Holds the core via stall_o until each access completes. Replaces the zero-latency data RAM and lets the core run with multi-cycle memory.

Parameters:
WORD_WIDTH, 32, data and address width
ADDR_W, 10, word-address bits (memory depth 2**ADDR_W words)
LATENCY, 2, wait cycles between request acceptance and response; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
mem_req_i  input  1  access request; core holds it and all request fields stable while stall_o=1
mem_we_i  input  1  1 = store, 0 = load
mem_size_i  input  3  RISC-V funct3 encoding: 0 B, 1 H, 2 W, 4 BU, 5 HU
addr_i  input  WORD_WIDTH  byte address
wdata_i  input  WORD_WIDTH  store data, right-aligned in the low bits
rdata_o  output  WORD_WIDTH  load result, valid while ready_o=1
ready_o  output  1  one-cycle completion pulse
err_o  output  1  valid with ready_o: misaligned access or illegal size
stall_o  output  1  freeze request to the core (combinational)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, counter 0, rdata_o=0, ready_o=0, err_o=0. RAM contents are not cleared.
- States: IDLE, WAIT, RESP.
- IDLE with mem_req_i=1:
  - Latch we, size, addr and wdata.
  - Legal and aligned: go to WAIT with cnt=LATENCY-1.
  - Otherwise: go directly to RESP with err flag set.
- WAIT:
  - cnt>0: decrement.
  - cnt=0: perform the access and go to RESP. Stores update the RAM on this edge; loads register the extended result into rdata_o.
- RESP: ready_o=1 for exactly one cycle, then unconditionally go to IDLE. rdata_o is held in later cycles; ready_o and err_o clear.
- stall_o = mem_req_i & (state != RESP). It is low during the RESP cycle, so the core advances, and low in IDLE when there is no request.
- Latency: request seen in cycle 0 gives ready_o in cycle LATENCY+1. An error response gives ready_o in cycle 1.
- Alignment: H/HU need addr[0]=0; W needs addr[1:0]=0. A misaligned access or size 3/6/7 raises err_o.
  - Stores with size 4/5 are also illegal.
  - An error access never writes the RAM and returns rdata_o=0.
- Store lanes:
  - SB writes byte lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes.
  - Untouched lanes are preserved.
- Load extension:
  - B and H are sign-extended from bit 7 and bit 15 respectively.
  - BU and HU are zero-extended.
  - W is returned unmodified.
- Stores return rdata_o=0.
- Word index = addr[ADDR_W+1:2]. Higher address bits are ignored, so accesses wrap modulo depth.
- mem_req_i dropping during WAIT is ignored; the latched transaction completes.
- A request present in the RESP cycle is not accepted. It is taken in the following IDLE cycle.
- Reset asserted during WAIT aborts the access: no RAM write, outputs return to their reset values.

Decomposition:
- Package data_mem_pkg holds:
  - size constants SZ_B=3'd0, SZ_H=3'd1, SZ_W=3'd2, SZ_BU=3'd4, SZ_HU=3'd5;
  - state enum {IDLE, WAIT, RESP};
  - an is_legal_size function.
- Sub-module mem_lane_align (combinational): generates byte-enables and the shifted write word from size, addr[1:0] and wdata. It also performs the load extract and extension. All other logic, including the FSM and RAM, lives in data_mem_responder.

Test Plan:
1. LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> stall_o high in cycles 0-2, ready_o in cycle 3, rdata_o=0xDEADBEEF, err_o=0.
2. SB 0x13 data 0x000000A5 after test 1 -> LB 0x13 gives 0xFFFFFFA5; LBU 0x13 gives 0x000000A5; LW 0x10 gives 0xA5ADBEEF.
3. SH 0x22 data 0x00008001 -> LH 0x22 gives 0xFFFF8001; LHU 0x22 gives 0x00008001; LW 0x20 gives 0x80010000 (RAM initialised to 0).
4. LW 0x11 and SH 0x23 -> ready_o and err_o in cycle 1, rdata_o=0, RAM unchanged. Size 3 request -> err_o=1.
5. SW 0x30 data 0x12345678; rst pulsed low during WAIT -> outputs 0 immediately. Later LW 0x30 returns the prior value (0).
6. Back-to-back: mem_req_i held high across two loads to 0x10 and 0x14 -> two ready_o pulses, in cycles 3 and 7.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants, state type and access-legality helpers
// for the data memory responder.
package data_mem_pkg;

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Unsigned sizes only exist for loads.
  function automatic logic is_legal_size(
    input logic [2:0] size,
    input logic       we
  );
    logic ok;
    case (size)
      SZ_B, SZ_H, SZ_W: ok = 1'b1;
      SZ_BU, SZ_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic is_aligned(
    input logic [2:0] size,
    input logic [1:0] lo
  );
    logic ok;
    case (size)
      SZ_H, SZ_HU: ok = !lo[0];
      SZ_W:        ok = (lo == 2'b00);
      default:     ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store enables/replication and
// load extraction with sign or zero extension.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [2:0]     i_size,
  input  logic [1:0]     i_lo,
  input  logic [W-1:0]   i_wdata,
  input  logic [W-1:0]   i_rword,
  output logic [W/8-1:0] o_be,
  output logic [W-1:0]   o_wword,
  output logic [W-1:0]   o_rext
);

  localparam int NB = W / 8;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_b;
  logic        w_h;
  logic        w_w;

  assign w_byte = i_rword[{i_lo, 3'b000} +: 8];
  assign w_half = i_rword[{i_lo[1], 4'b0000} +: 16];

  assign w_b = (i_size == SZ_B) | (i_size == SZ_BU);
  assign w_h = (i_size == SZ_H) | (i_size == SZ_HU);
  assign w_w = (i_size == SZ_W);

  // Data is replicated across lanes; enables pick the target.
  always_comb begin
    o_be    = '0;
    o_wword = '0;
    unique case (1'b1)
      w_b: begin
        o_be    = NB'(1) << i_lo;
        o_wword = {NB{i_wdata[7:0]}};
      end
      w_h: begin
        o_be    = NB'(3) << {i_lo[1], 1'b0};
        o_wword = {(NB/2){i_wdata[15:0]}};
      end
      w_w: begin
        o_be    = '1;
        o_wword = i_wdata;
      end
      default: begin
        o_be    = '0;
        o_wword = '0;
      end
    endcase
  end

  always_comb begin
    o_rext = '0;
    case (i_size)
      SZ_B:    o_rext = {{(W-8){w_byte[7]}}, w_byte};
      SZ_BU:   o_rext = {{(W-8){1'b0}}, w_byte};
      SZ_H:    o_rext = {{(W-16){w_half[15]}}, w_half};
      SZ_HU:   o_rext = {{(W-16){1'b0}}, w_half};
      SZ_W:    o_rext = i_rword;
      default: o_rext = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data RAM behind the core load/store port,
// stalling the core until each access completes.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_W     = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [2:0]            mem_size_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  err_o,
  output logic                  stall_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = WORD_WIDTH / 8;

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [2:0]              r_size;
  logic [ADDR_W+1:0]       r_addr;
  logic [WORD_WIDTH-1:0]   r_wdata;
  logic [WORD_WIDTH-1:0]   r_rdata;
  logic                    r_ready;
  logic                    r_err;
  logic [WORD_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_ok;
  logic                    w_fire;
  logic [ADDR_W-1:0]       w_idx;
  logic [NB-1:0]           w_be;
  logic [WORD_WIDTH-1:0]   w_wword;
  logic [WORD_WIDTH-1:0]   w_rword;
  logic [WORD_WIDTH-1:0]   w_rext;
  logic                    w_unused;

  // Upper address bits alias onto the same words.
  assign w_unused = ^addr_i[WORD_WIDTH-1:ADDR_W+2];

  assign w_ok = is_legal_size(mem_size_i, mem_we_i)
              & is_aligned(mem_size_i, addr_i[1:0]);

  assign w_idx   = r_addr[ADDR_W+1:2];
  assign w_rword = r_mem[w_idx];
  assign w_fire  = (r_state == WAIT) && (r_cnt == 4'd0);

  mem_lane_align #(
    .W (WORD_WIDTH)
  ) u_align (
    .i_size  (r_size),
    .i_lo    (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rword (w_rword),
    .o_be    (w_be),
    .o_wword (w_wword),
    .o_rext  (w_rext)
  );

  always_ff @(posedge clk) begin
    if (w_fire && r_we) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (mem_req_i) begin
            r_we    <= mem_we_i;
            r_size  <= mem_size_i;
            r_addr  <= addr_i[ADDR_W+1:0];
            r_wdata <= wdata_i;
            if (w_ok) begin
              r_state <= WAIT;
              r_cnt   <= 4'(LATENCY - 1);
            end else begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_err   <= 1'b1;
              r_rdata <= '0;
            end
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_rdata <= r_we ? '0 : w_rext;
          end
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdata_o = r_rdata;
  assign ready_o = r_ready;
  assign err_o   = r_err;
  assign stall_o = mem_req_i & (r_state != RESP);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scenario tasks plus randomized traffic checked against
// a byte-addressed reference memory.
module tb_data_mem_responder;
  import data_mem_pkg::*;

  localparam int LAT    = 2;
  localparam int AW     = 10;
  localparam int NBYTES = 4 * (2 ** AW);

  typedef struct {
    logic        we;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [2:0]  mem_size_i = 3'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        ready_o;
  logic        err_o;
  logic        stall_o;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  logic [7:0] mb [NBYTES];

  data_mem_responder #(
    .WORD_WIDTH (32),
    .ADDR_W     (AW),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req_i  (mem_req_i),
    .mem_we_i   (mem_we_i),
    .mem_size_i (mem_size_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
    .err_o      (err_o),
    .stall_o    (stall_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: little-endian byte array, accesses of 1/2/4 bytes.
  task automatic model(
    input  logic        we,
    input  logic [2:0]  sz,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat
  );
    int n;
    int ba;
    logic [31:0] acc;
    case (sz)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    if (n == 0) er = 1'b1;
    else er = (we && sz[2]) || ((a % n) != 0);
    rd  = '0;
    lat = er ? 1 : LAT + 1;
    if (!er) begin
      ba = int'(a & (NBYTES - 1));
      if (we) begin
        for (int i = 0; i < n; i++) mb[ba+i] = wd[8*i +: 8];
      end else begin
        acc = '0;
        for (int i = 0; i < n; i++) acc[8*i +: 8] = mb[ba+i];
        if (!sz[2] && n < 4 && acc[8*n-1])
          acc = acc | (32'hFFFF_FFFF << (8 * n));
        rd = acc;
      end
    end
  endtask

  // Drives one request; reports response, latency and stall behaviour.
  task automatic access(
    input  logic        we,
    input  logic [2:0]  sz,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        er,
    output int          lat,
    output logic        st,
    output int          rc
  );
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_size_i = sz;
    addr_i     = a;
    wdata_i    = wd;
    lat = -1;
    rc  = -1;
    st  = 1'b1;
    rd  = 'x;
    er  = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready_o === 1'b1) begin
        lat = k;
        rc  = cyc;
        rd  = rdata_o;
        er  = err_o;
        if (stall_o !== 1'b0) st = 1'b0;
        break;
      end
      if (stall_o !== 1'b1) st = 1'b0;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    mem_req_i = 1'b0;
  endtask

  task automatic init_ram();
    logic [31:0] rd;
    logic er, st;
    int lat, rc;
    for (int w = 0; w < 64; w++)
      access(1'b1, SZ_W, 32'(w * 4), '0, rd, er, lat, st, rc);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (rdata_o !== '0 || ready_o !== 1'b0 || err_o !== 1'b0 || stall_o !== 1'b0)
      $display("FAIL reset rdata=%h ready=%b err=%b stall=%b exp 0/0/0/0",
               rdata_o, ready_o, err_o, stall_o);
    else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_total++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0)
      $display("FAIL idle_no_req stall=%b ready=%b exp 0/0", stall_o, ready_o);
    else n_pass++;
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    logic [31:0] rd, mrd;
    logic er, st, mer;
    int lat, rc, mlat;
    foreach (v[i]) begin
      access(v[i].we, v[i].sz, v[i].a, v[i].wd, rd, er, lat, st, rc);
      model(v[i].we, v[i].sz, v[i].a, v[i].wd, mrd, mer, mlat);
      n_total++;
      if (rd !== v[i].exp || er !== 1'b0 || lat != LAT + 1 || !st)
        $display("FAIL %s[%0d] rdata=%h err=%b lat=%0d stall_ok=%b exp rdata=%h err=0 lat=%0d",
                 name, i, rd, er, lat, st, v[i].exp, LAT + 1);
      else n_pass++;
    end
  endtask

  task automatic test_word();
    vec_t v[$];
    v.push_back('{1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, 32'h0});
    v.push_back('{1'b0, SZ_W, 32'h10, 32'h0, 32'hDEAD_BEEF});
    test_vectors("word", v);
  endtask

  task automatic test_byte();
    vec_t v[$];
    v.push_back('{1'b1, SZ_B,  32'h13, 32'h0000_00A5, 32'h0});
    v.push_back('{1'b0, SZ_B,  32'h13, 32'h0, 32'hFFFF_FFA5});
    v.push_back('{1'b0, SZ_BU, 32'h13, 32'h0, 32'h0000_00A5});
    v.push_back('{1'b0, SZ_W,  32'h10, 32'h0, 32'hA5AD_BEEF});
    test_vectors("byte", v);
  endtask

  task automatic test_half();
    vec_t v[$];
    v.push_back('{1'b1, SZ_H,  32'h22, 32'h0000_8001, 32'h0});
    v.push_back('{1'b0, SZ_H,  32'h22, 32'h0, 32'hFFFF_8001});
    v.push_back('{1'b0, SZ_HU, 32'h22, 32'h0, 32'h0000_8001});
    v.push_back('{1'b0, SZ_W,  32'h20, 32'h0, 32'h8001_0000});
    test_vectors("half", v);
  endtask

  task automatic test_errors();
    vec_t v[$];
    logic [31:0] rd;
    logic er, st;
    int lat, rc;
    v.push_back('{1'b0, SZ_W,  32'h11, 32'h0, 32'h0});
    v.push_back('{1'b1, SZ_H,  32'h23, 32'hFFFF, 32'h0});
    v.push_back('{1'b0, 3'd3,  32'h20, 32'h0, 32'h0});
    v.push_back('{1'b1, SZ_BU, 32'h20, 32'hFF, 32'h0});
    v.push_back('{1'b1, SZ_W,  32'h22, 32'hFFFF_FFFF, 32'h0});
    v.push_back('{1'b0, 3'd7,  32'h20, 32'h0, 32'h0});
    foreach (v[i]) begin
      access(v[i].we, v[i].sz, v[i].a, v[i].wd, rd, er, lat, st, rc);
      n_total++;
      if (rd !== '0 || er !== 1'b1 || lat != 1 || !st)
        $display("FAIL err[%0d] rdata=%h err=%b lat=%0d stall_ok=%b exp rdata=0 err=1 lat=1",
                 i, rd, er, lat, st);
      else n_pass++;
    end
    access(1'b0, SZ_W, 32'h20, '0, rd, er, lat, st, rc);
    n_total++;
    if (rd !== 32'h8001_0000 || er !== 1'b0)
      $display("FAIL err_ram_0x20 rdata=%h err=%b exp 80010000/0", rd, er);
    else n_pass++;
  endtask

  task automatic test_reset_wait();
    logic [31:0] rd, mrd;
    logic er, st, mer;
    int lat, rc, mlat;
    access(1'b0, SZ_W, 32'h10, '0, rd, er, lat, st, rc);
    n_total++;
    if (rd !== 32'hA5AD_BEEF)
      $display("FAIL pre_reset_load rdata=%h exp a5adbeef", rd);
    else n_pass++;
    mem_req_i  = 1'b1;
    mem_we_i   = 1'b1;
    mem_size_i = SZ_W;
    addr_i     = 32'h30;
    wdata_i    = 32'h1234_5678;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_total++;
    if (rdata_o !== '0 || ready_o !== 1'b0 || err_o !== 1'b0)
      $display("FAIL reset_in_wait rdata=%h ready=%b err=%b exp 0/0/0",
               rdata_o, ready_o, err_o);
    else n_pass++;
    mem_req_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b0, SZ_W, 32'h30, '0, rd, er, lat, st, rc);
    model(1'b0, SZ_W, 32'h30, '0, mrd, mer, mlat);
    n_total++;
    if (rd !== mrd || er !== mer || rd !== 32'h0)
      $display("FAIL aborted_store rdata=%h err=%b exp %h/%b", rd, er, mrd, mer);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd1, rd2, m1, m2;
    logic er1, er2, st1, st2, me;
    int l1, l2, rc1, rc2, c0, ml;
    c0 = cyc;
    access(1'b0, SZ_W, 32'h10, '0, rd1, er1, l1, st1, rc1);
    access(1'b0, SZ_W, 32'h14, '0, rd2, er2, l2, st2, rc2);
    model(1'b0, SZ_W, 32'h10, '0, m1, me, ml);
    model(1'b0, SZ_W, 32'h14, '0, m2, me, ml);
    n_total++;
    if (rc1 - c0 != LAT + 1 || rc2 - c0 != 2 * (LAT + 2) - 1)
      $display("FAIL b2b_timing ready cycles %0d,%0d exp %0d,%0d",
               rc1 - c0, rc2 - c0, LAT + 1, 2 * (LAT + 2) - 1);
    else n_pass++;
    n_total++;
    if (rd1 !== m1 || rd2 !== m2 || er1 !== 1'b0 || er2 !== 1'b0)
      $display("FAIL b2b_data rdata %h,%h err %b,%b exp %h,%h 0,0",
               rd1, rd2, er1, er2, m1, m2);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] rd, mrd, a, wd;
    logic er, st, mer, we;
    logic [2:0] sz;
    int lat, rc, mlat, pick;
    for (int t = 0; t < 300; t++) begin
      we   = 1'($urandom_range(0, 1));
      pick = $urandom_range(0, 10);
      sz   = (pick > 7) ? SZ_W : 3'(pick);
      a    = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 255));
      wd   = $urandom;
      access(we, sz, a, wd, rd, er, lat, st, rc);
      model(we, sz, a, wd, mrd, mer, mlat);
      n_total++;
      if (rd !== mrd || er !== mer || lat != mlat || !st)
        $display("FAIL rand[%0d] we=%b sz=%0d a=%h rdata=%h err=%b lat=%0d stall_ok=%b exp %h/%b/%0d",
                 t, we, sz, a, rd, er, lat, st, mrd, mer, mlat);
      else n_pass++;
    end
  endtask

  initial begin
    foreach (mb[i]) mb[i] = 8'h00;
    test_reset();
    init_ram();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_wait();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
